// File: rtl/fetch_stage_pkg.sv
//------------------------------------------------------------------------------
// Module  : fetch_pkg
// Brief   : Shared types and constants for the instruction-fetch stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
//------------------------------------------------------------------------------
// Module  : fetch_stage_if
// Brief   : Instruction-memory request/response bus between fetch and memory.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/fetch_stage_fifo.sv
//------------------------------------------------------------------------------
// Module  : fetch_fifo
// Brief   : Small synchronous FIFO holding fetched {pc, inst}; flush wins.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic                     flush,
  input  wire logic [WIDTH-1:0]         wdata,
  output logic      [WIDTH-1:0]         rdata,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   count
);
  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// Module  : fetch_stage
// Brief   : Single-outstanding instruction fetch with redirect, stall and FIFO.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        stall,
  input  wire logic        redirect_valid,
  input  wire logic [31:0] redirect_pc,
  fetch_stage_if.master    imem,
  output logic      [31:0] inst_out,
  output logic      [31:0] pc_out,
  output logic      [31:0] pc_plus4_out,
  output logic             valid_out
);
  localparam int            CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          valid_q, valid_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pc4_q, pc4_d;
  logic          issue;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [63:0]   fifo_wdata, fifo_rdata;

  assign imem.req  = issue;
  assign imem.addr = fetch_pc_q;

  // While waiting, fetch_pc has already advanced past the outstanding request.
  assign fifo_wdata = {fetch_pc_q - PC_INC, imem.rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    issue      = 1'b0;
    fifo_push  = 1'b0;
    unique case (state_q)
      IDLE:  state_d = REQ;
      REQ: begin
        issue = (fifo_count < DEPTH_C) & ~redirect_valid;
        if (issue && imem.ready) begin
          fetch_pc_d = fetch_pc_q + PC_INC;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem.rvalid) begin
          fifo_push = ~redirect_valid & ~fifo_full;
          state_d   = REQ;
        end
      end
      DRAIN: begin
        if (imem.rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    // A redirect while a response is still owed must swallow that response.
    if (redirect_valid) begin
      fetch_pc_d = align_word(redirect_pc);
      if (state_q == WAIT && !imem.rvalid) state_d = DRAIN;
      else if (state_q != DRAIN)           state_d = REQ;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    pc4_d    = pc4_q;
    fifo_pop = 1'b0;
    if (redirect_valid) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else if (!stall) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        valid_d  = 1'b1;
        inst_d   = fifo_rdata[31:0];
        pc_d     = fifo_rdata[63:32];
        pc4_d    = fifo_rdata[63:32] + PC_INC;
      end else begin
        valid_d = 1'b0;
        inst_d  = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      inst_q     <= NOP_INST;
      pc_q       <= '0;
      pc4_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
    end
  end

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign valid_out    = valid_q;
  assign inst_out     = inst_q;
  assign pc_out       = pc_q;
  assign pc_plus4_out = pc4_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// Module  : tb_fetch_stage
// Brief   : Randomized bench for fetch_stage against a queue-based fetch model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk            = 1'b0;
  logic        rst_n          = 1'b0;
  logic        stall          = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic [31:0] inst_out, pc_out, pc_plus4_out;
  logic        valid_out;

  fetch_stage_if imem ();

  fetch_stage #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .pc_plus4_out   (pc_plus4_out),
    .valid_out      (valid_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a request is "owed" (busy) or not; a redirect marks it stale.
  bit          m_started, m_busy, m_stale;
  logic [31:0] m_pc, m_reqaddr;
  logic [63:0] m_q[$];
  logic        m_valid;
  logic [31:0] m_inst, m_pcout, m_pc4;

  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  bit          dut_accept;
  logic [31:0] dut_addr;
  int          stall_burst = 0;

  task automatic model_reset();
    m_started = 0; m_busy = 0; m_stale = 0;
    m_pc = RST_PC; m_q.delete();
    m_valid = 0; m_inst = 0; m_pcout = 0; m_pc4 = 0;
  endtask

  function automatic bit exp_req();
    return m_started && !m_busy && (m_q.size() < DEPTH) && !redirect_valid;
  endfunction

  task automatic model_step();
    bit          acc;
    bit          resp;
    logic [63:0] h;
    acc  = exp_req() && imem.ready;
    resp = m_busy && imem.rvalid;
    if (redirect_valid) begin
      m_q.delete(); m_valid = 0; m_inst = 0;
    end else if (!stall) begin
      if (m_q.size() > 0) begin
        h = m_q.pop_front();
        m_valid = 1; m_inst = h[31:0]; m_pcout = h[63:32]; m_pc4 = h[63:32] + 32'd4;
      end else begin
        m_valid = 0; m_inst = 0;
      end
    end
    if (resp) begin
      if (!m_stale && !redirect_valid) m_q.push_back({m_reqaddr, imem.rdata});
      m_busy = 0; m_stale = 0;
    end else if (redirect_valid && m_busy) begin
      m_stale = 1;
    end
    if (redirect_valid) m_pc = {redirect_pc[31:2], 2'b00};
    if (acc) begin
      m_busy = 1; m_reqaddr = m_pc; m_pc = m_pc + 32'd4;
    end
    m_started = 1;
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, ".req"}, {31'd0, imem.req}, {31'd0, exp_req()});
    if (exp_req()) check({tag, ".addr"}, imem.addr, m_pc);
    check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, m_valid});
    check({tag, ".inst"},  inst_out,     m_inst);
    check({tag, ".pc"},    pc_out,       m_pcout);
    check({tag, ".pc4"},   pc_plus4_out, m_pc4);
  endtask

  // Called at a negedge; leaves the bench at the next negedge.
  task automatic run_cycle(input bit rnd, input bit stale_word);
    int sel;
    if (rnd) begin
      if (stall_burst == 0 && $urandom_range(0, 19) == 0) stall_burst = 6;
      stall = (stall_burst > 0) || ($urandom_range(0, 4) == 0);
      if (stall_burst > 0) stall_burst--;
      redirect_valid = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 3);
      redirect_pc = (sel == 0) ? 32'hFFFF_FFFC : (sel == 1) ? 32'h0000_0103 : $urandom;
      imem.ready = ($urandom_range(0, 9) < 7);
    end else begin
      stall = 0; redirect_valid = 0; imem.ready = 1;
    end
    if (stale_word) begin
      imem.rvalid = 1; imem.rdata = 32'hDEAD_BEEF;
    end else if (mem_pend && mem_cnt == 0) begin
      imem.rvalid = 1; imem.rdata = mem_addr ^ 32'hA5A5_0000; mem_pend = 0;
    end else begin
      imem.rvalid = 0; imem.rdata = $urandom;
      if (mem_pend) mem_cnt--;
    end
    #1;
    compare_outputs(rnd ? "rnd" : "seq");
    dut_accept = imem.req && imem.ready;
    dut_addr   = imem.addr;
    @(posedge clk);
    model_step();
    if (dut_accept) begin
      mem_pend = 1; mem_addr = dut_addr;
      mem_cnt  = rnd ? $urandom_range(0, 2) : 0;
    end
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".req"},   {31'd0, imem.req},  32'd0);
    check({tag, ".valid"}, {31'd0, valid_out}, 32'd0);
    check({tag, ".inst"},  inst_out,           32'd0);
    check({tag, ".pc"},    pc_out,             32'd0);
    check({tag, ".pc4"},   pc_plus4_out,       32'd0);
  endtask

  initial begin
    bit found;
    imem.ready = 0; imem.rvalid = 0; imem.rdata = '0;
    mem_pend = 0; mem_cnt = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks("por");
    rst_n = 1;
    for (int i = 0; i < 30; i++)  run_cycle(0, 0);
    for (int i = 0; i < 800; i++) run_cycle(1, 0);

    // Reset with a request outstanding; its response shows up after release.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      run_cycle(0, 0);
      found = mem_pend;
    end
    check("wait_accept", {31'd0, found}, 32'd1);
    rst_n = 0; imem.rvalid = 0; stall = 0; redirect_valid = 0;
    #1;
    reset_checks("mid_rst");
    model_reset();
    mem_pend = 0;
    @(negedge clk);
    reset_checks("mid_rst_hold");
    rst_n = 1;
    run_cycle(0, 1);
    run_cycle(0, 1);
    for (int i = 0; i < 20; i++)  run_cycle(0, 0);
    for (int i = 0; i < 600; i++) run_cycle(1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
